// File: rtl/int2float_rr_sched_if.sv
// Request/result bus between the int2float scheduler and its neighbours.
// Latency: none, this is wiring only.
// Backpressure: req_ready grants one requester per cycle; out_ready stalls the result stage.
interface int2float_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*11-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_m;
  logic [2:0]         out_e;
  logic [IDW-1:0]     out_id;

  // Front-end side: supplies operands, consumes results.
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_m, out_e, out_id
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_m, out_e, out_id
  );
endinterface

// File: rtl/int2float_rr_sched.sv
// Round-robin scheduler sharing one int2float converter among NREQ requesters, one conversion per cycle.
// Latency: operand accepted at edge t is presented on the outputs after edge t+1.
// Backpressure: out_ready low holds S2, S1 fills behind it, then req_ready drops to 0.

// Converter: 11-bit unsigned B -> 4-bit mantissa M, 3-bit exponent E (B ~ M * 2^E, truncated).
module int2float (
  input  logic [10:0] i_b,
  output logic [3:0]  o_m,
  output logic [2:0]  o_e
);
  // Leading-one detect: keep the top four significant bits, the exponent is the shift applied.
  always_comb begin
    o_m = i_b[3:0];
    o_e = 3'd0;
    for (int p = 4; p <= 10; p++) begin
      if (i_b[p]) begin
        o_m = i_b[p -: 4];
        o_e = 3'(p - 3);
      end
    end
  end
endmodule

module int2float_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  int2float_rr_sched_if.slave  bus,
  output logic                 o_busy,
  output logic [CNTW-1:0]      o_conv_count
);
  // S1: granted operand and its tag.
  logic            r_s1_v;
  logic [10:0]     r_s1_dat;
  logic [IDW-1:0]  r_s1_id;
  // S2: converted result and its tag.
  logic            r_out_v;
  logic [3:0]      r_out_m;
  logic [2:0]      r_out_e;
  logic [IDW-1:0]  r_out_id;
  // Arbitration pointer (highest-priority requester) and completion counter.
  logic [IDW-1:0]  r_ptr;
  logic [CNTW-1:0] r_cnt;

  logic            w_out_hs;
  logic            w_s2_load;
  logic            w_s1_free;
  logic            w_grant_ok;
  logic [IDW-1:0]  w_scan [NREQ];
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_gnt_any;
  logic [10:0]     w_gnt_dat;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [3:0]      w_cv_m;
  logic [2:0]      w_cv_e;

  // Stage advance: S2 takes S1 whenever S2 is empty or draining this cycle,
  // and S1 can take a new operand whenever it is empty or emptying.
  assign w_out_hs   = r_out_v & bus.out_ready;
  assign w_s2_load  = r_s1_v & (~r_out_v | bus.out_ready);
  assign w_s1_free  = ~r_s1_v | w_s2_load;
  // Reset gates the grant so no requester sees an accept that the reset would discard.
  assign w_grant_ok = i_rst_n & i_en & w_s1_free;

  // Scan order starting at the pointer, wrapping modulo NREQ.
  genvar gk;
  generate
    for (gk = 0; gk < NREQ; gk++) begin : g_scan
      assign w_scan[gk] = IDW'((int'(r_ptr) + gk) % NREQ);
    end
  endgenerate

  // Round-robin pick: first valid requester in scan order; depends on valids only, never on data.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant_ok && !w_gnt_any && bus.req_valid[w_scan[k]]) begin
        w_gnt[w_scan[k]] = 1'b1;
        w_gnt_idx        = w_scan[k];
        w_gnt_any        = 1'b1;
      end
    end
  end

  assign w_gnt_dat = bus.req_data[11*w_gnt_idx +: 11];
  assign w_ptr_nxt = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;

  // The single shared converter sits between S1 and S2.
  int2float u_cv (
    .i_b (r_s1_dat),
    .o_m (w_cv_m),
    .o_e (w_cv_e)
  );

  // Pipeline registers, pointer and counter; reset discards everything in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_dat <= '0;
      r_s1_id  <= '0;
      r_out_v  <= 1'b0;
      r_out_m  <= '0;
      r_out_e  <= '0;
      r_out_id <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_gnt_any) begin
        r_s1_v   <= 1'b1;
        r_s1_dat <= w_gnt_dat;
        r_s1_id  <= w_gnt_idx;
        r_ptr    <= w_ptr_nxt;
      end else if (w_s2_load) begin
        r_s1_v <= 1'b0;
      end

      if (w_s2_load) begin
        r_out_v  <= 1'b1;
        r_out_m  <= w_cv_m;
        r_out_e  <= w_cv_e;
        r_out_id <= r_s1_id;
      end else if (w_out_hs) begin
        r_out_v <= 1'b0;
      end

      if (w_out_hs) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.out_valid = r_out_v;
  assign bus.out_m     = r_out_m;
  assign bus.out_e     = r_out_e;
  assign bus.out_id    = r_out_id;
  assign o_busy        = r_s1_v | r_out_v;
  assign o_conv_count  = r_cnt;
endmodule

// File: tb/tb_int2float_rr_sched.sv
// Bench for int2float_rr_sched: table vectors, directed corner sequences, random traffic vs a reference model.
// Latency: checks one-cycle accept-to-output timing.
// Backpressure: exercises out_ready stalls, en gating and reset mid-flight.
module tb_int2float_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            busy;
  logic [CNTW-1:0] conv_count;

  int checks = 0;
  int errors = 0;

  int2float_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  int2float_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .bus          (bus.slave),
    .o_busy       (busy),
    .o_conv_count (conv_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Golden converter: shift right until the value fits in 4 bits, counting the shifts.
  function automatic logic [6:0] golden(input int b);
    int v;
    int e;
    v = b;
    e = 0;
    while (v >= 16) begin
      v = v / 2;
      e++;
    end
    return {v[3:0], e[2:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    en            = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         id;
    int         b;
    logic [3:0] m;
    logic [2:0] e;
  } vec_t;

  typedef struct {
    int id;
    int b;
  } item_t;

  vec_t        tbl [10];
  item_t       q [$];
  item_t       it;
  logic [6:0]  g;
  logic [9:0]  snap;
  logic [8:0]  expv;
  int          acc, hs, n, gnt, ptr, deliv, idx;
  int          cnt [4];
  bit          just, exp_ov;

  initial begin
    tbl[0] = '{0, 0,    4'd0,  3'd0};
    tbl[1] = '{2, 1024, 4'd8,  3'd7};
    tbl[2] = '{1, 15,   4'd15, 3'd0};
    tbl[3] = '{3, 16,   4'd8,  3'd1};
    tbl[4] = '{0, 2047, 4'd15, 3'd7};
    tbl[5] = '{1, 100,  4'd12, 3'd3};
    tbl[6] = '{2, 31,   4'd15, 3'd1};
    tbl[7] = '{3, 1023, 4'd15, 3'd6};
    tbl[8] = '{0, 576,  4'd9,  3'd6};
    tbl[9] = '{1, 8,    4'd8,  3'd0};

    // Reset state, with requests pending during reset.
    idle();
    bus.req_valid = 4'hF;
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_me_id", {bus.out_m, bus.out_e, bus.out_id}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(conv_count), 0);
    do_reset();

    // Table vectors: one requester at a time, result one cycle after accept.
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = '0;
      bus.req_valid[tbl[k].id] = 1'b1;
      bus.req_data[11*tbl[k].id +: 11] = 11'(tbl[k].b);
      #1;
      chk("tbl_req_ready", 32'(bus.req_ready), 32'(1 << tbl[k].id));
      cyc();
      bus.req_valid = '0;
      chk("tbl_busy", 32'(busy), 1);
      chk("tbl_early_valid", 32'(bus.out_valid), 0);
      cyc();
      chk("tbl_out_valid", 32'(bus.out_valid), 1);
      chk("tbl_out", {bus.out_m, bus.out_e, bus.out_id}, {tbl[k].m, tbl[k].e, 2'(tbl[k].id)});
      cyc();
      chk("tbl_out_done", 32'(bus.out_valid), 0);
      chk("tbl_count", 32'(conv_count), 32'((k + 1) % 16));
    end

    // Full sweep of operands on requester 0 at full rate.
    do_reset();
    for (int i = 0; i < 2050; i++) begin
      bus.req_valid = (i < 2048) ? 4'b0001 : 4'b0000;
      bus.req_data[10:0] = 11'(i);
      #1;
      if (i >= 2) begin
        g = golden(i - 2);
        chk("sweep", {bus.out_valid, bus.out_m, bus.out_e, bus.out_id}, {1'b1, g, 2'd0});
      end
      cyc();
    end

    // Fairness with all requesters valid.
    do_reset();
    bus.req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) bus.req_data[11*i +: 11] = 11'(100*i + 5);
    n = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 120 && n < 100; c++) begin
      #1;
      if (c < 100) chk("fair_grant", 32'(bus.req_ready), 32'(1 << (c % 4)));
      if (bus.out_valid && bus.out_ready) begin
        g = golden(100*(n % 4) + 5);
        chk("fair_out", {bus.out_id, bus.out_m, bus.out_e}, {2'(n % 4), g});
        cnt[bus.out_id]++;
        n++;
      end
      cyc();
    end
    chk("fair_total", 32'(n), 100);
    for (int i = 0; i < 4; i++) chk("fair_share", 32'(cnt[i]), 25);

    // Backpressure: exactly two accepts, then stall with stable outputs.
    do_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) bus.req_data[11*i +: 11] = 11'(300*i + 17);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (|(bus.req_valid & bus.req_ready)) acc++;
      if (c == 2) snap = {bus.out_valid, bus.out_m, bus.out_e, bus.out_id};
      if (c > 2) chk("bp_stable", {bus.out_valid, bus.out_m, bus.out_e, bus.out_id}, snap);
      cyc();
    end
    chk("bp_accepts", 32'(acc), 2);
    chk("bp_req_ready", 32'(bus.req_ready), 0);
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("bp_no_gap", 32'(bus.out_valid), 1);
      if (bus.out_valid) begin
        g = golden(300*(n % 4) + 17);
        chk("bp_order", {bus.out_id, bus.out_m, bus.out_e}, {2'(n % 4), g});
        n++;
      end
      cyc();
    end

    // Reset mid-flight with both stages full.
    do_reset();
    bus.req_valid = 4'hF;
    for (int c = 0; c < 5; c++) cyc();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
    chk("mid_busy_before", 32'(busy), 1);
    chk("mid_valid_before", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    cyc();
    chk("mid_out_valid", 32'(bus.out_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_count", 32'(conv_count), 0);
    rst_n = 1'b1;
    #1;
    chk("mid_first_grant", 32'(bus.req_ready), 1);

    // en=0 with S1 full: one result drains, no new grants, then resume from pointer.
    do_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_data[22 +: 11] = 11'd1024;
    cyc();
    en = 1'b0;
    bus.req_valid = 4'hF;
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      bus.out_ready = (c >= 2);
      #1;
      chk("en_no_grant", 32'(bus.req_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("en_drain_out", {bus.out_id, bus.out_m, bus.out_e}, {2'd2, 4'd8, 3'd7});
        hs++;
      end
      cyc();
    end
    chk("en_drain_count", 32'(hs), 1);
    chk("en_idle_busy", 32'(busy), 0);
    en = 1'b1;
    #1;
    chk("en_resume_ptr", 32'(bus.req_ready), 32'h8);

    // Counter wrap: 17 handshakes on a 4-bit counter.
    do_reset();
    bus.req_valid = 4'b0001;
    hs = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.out_valid && bus.out_ready) hs++;
      cyc();
      if (hs == 17) break;
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("wrap_hs", 32'(hs), 17);
    chk("wrap_count", 32'(conv_count), 1);

    // Random traffic against a reference model: pipeline holds at most two operands,
    // results leave in acceptance order.
    do_reset();
    q.delete();
    ptr = 0;
    deliv = 0;
    just = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      en            = ($urandom_range(0, 9) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++) bus.req_data[11*i +: 11] = 11'($urandom_range(0, 2047));
      #1;
      exp_ov = (q.size() >= 2) || (q.size() == 1 && !just);
      chk("rnd_out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("rnd_busy", 32'(busy), 32'(q.size() > 0));
      chk("rnd_count", 32'(conv_count), 32'(deliv % 16));
      gnt = -1;
      if (en && (q.size() < 2 || bus.out_ready)) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (ptr + k) % NREQ;
          if (gnt < 0 && bus.req_valid[idx]) gnt = idx;
        end
      end
      chk("rnd_req_ready", 32'(bus.req_ready), (gnt < 0) ? 0 : 32'(1 << gnt));
      if (exp_ov && bus.out_ready && q.size() > 0) begin
        g = golden(q[0].b);
        expv = {2'(q[0].id), g};
        chk("rnd_out", {bus.out_id, bus.out_m, bus.out_e}, 32'(expv));
        void'(q.pop_front());
        deliv++;
      end
      if (gnt >= 0) begin
        it.id = gnt;
        it.b  = int'(bus.req_data[11*gnt +: 11]);
        q.push_back(it);
        ptr  = (gnt + 1) % NREQ;
        just = 1'b1;
      end else begin
        just = 1'b0;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
